// File: rtl/instr_encoder_loader.sv
// Packs decoder fields into ARM words and streams legal ones into program memory, one word per 2 cycles.
// Holds the CPU in reset until the last word (or capacity) is written; in_ready is low while writing or done.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [11:0] Src2,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [8:0]  count
);

  typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

  localparam logic [8:0] MAX_CNT = 9'(MAX_WORDS);

  state_t      state;
  logic        last_q;
  logic        legal;
  logic [31:0] word;
  logic [8:0]  count_inc;

  assign word      = {Cond, Op, Funct, Rn, Rd, Src2};
  assign count_inc = count + 9'd1;

  // Only encodings the multicycle decoder actually executes are let through.
  always_comb begin
    legal = 1'b0;
    case (Op)
      2'b00:   legal = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010) ||
                       (Funct[4:1] == 4'b0000) || (Funct[4:1] == 4'b1100);
      2'b01:   legal = 1'b1;
      2'b10:   legal = Funct[5];
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      count    <= '0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      mem_we   <= 1'b0;
      in_ready <= 1'b1;
      mem_adr  <= BASE_ADDR;
      mem_wd   <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            last_q <= in_last;
            if (legal) begin
              mem_wd   <= word;
              mem_adr  <= BASE_ADDR + {21'd0, count, 2'b00};
              mem_we   <= 1'b1;
              in_ready <= 1'b0;
              state    <= WRITE;
            end else begin
              err <= 1'b1;
              if (in_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
                state    <= DONE;
              end
            end
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          count  <= count_inc;
          // Capacity ends the session just like an explicit last word.
          if (last_q || (count_inc == MAX_CNT)) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        DONE: begin
          if (start) begin
            count    <= '0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        default: begin
          mem_we   <= 1'b0;
          in_ready <= 1'b1;
          state    <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: a queue-based program model predicts every write,
// the final count/err and the accept/refuse decision for each field set.
module tb_instr_encoder_loader;

  localparam int          MAXW = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [11:0] Src2;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [8:0]  count;

  instr_encoder_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .cpu_hold(cpu_hold),
    .done(done), .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  int          exp_count;
  bit          exp_err;
  bit          exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  // Write monitor: record every memory write as {adr, data}.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      obs_q.push_back({mem_adr, mem_wd});
      check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  function automatic bit legal_ref(input logic [31:0] w);
    logic [1:0] op;
    logic [3:0] cmd;
    op  = w[27:26];
    cmd = w[24:21];
    if (op == 2'b01) return 1'b1;
    if (op == 2'b10) return w[25];
    if (op == 2'b00) return (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
    return 1'b0;
  endfunction

  function automatic logic [31:0] make_legal();
    logic [31:0] w;
    logic [3:0]  cmds [4];
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12};
    w = $urandom;
    case ($urandom_range(2))
      0: w[27:26] = 2'b01;
      1: begin w[27:26] = 2'b10; w[25] = 1'b1; end
      default: begin w[27:26] = 2'b00; w[24:21] = cmds[$urandom_range(3)]; end
    endcase
    return w;
  endfunction

  task automatic drive_fields(input logic [31:0] w);
    {Cond, Op, Funct, Rn, Rd, Src2} = w;
  endtask

  // Present a field set for up to 8 cycles; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] w, input bit last, output bit acc);
    drive_fields(w);
    in_last  = last;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      acc = (in_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    drive_fields($urandom);
  endtask

  task automatic put(input logic [31:0] w, input bit last);
    bit acc;
    bit want;
    want = !exp_done;
    send(w, last, acc);
    check("accepted", {31'd0, acc}, {31'd0, want});
    if (acc && want) begin
      if (legal_ref(w)) begin
        exp_q.push_back({BASE + 32'(exp_count * 4), w});
        exp_count++;
        if (last || exp_count == MAXW) exp_done = 1'b1;
      end else begin
        exp_err = 1'b1;
        if (last) exp_done = 1'b1;
      end
    end
  endtask

  task automatic finish_session(input string tag);
    for (int i = 0; i < 6 && done !== 1'b1; i++) @(negedge clk);
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_adr"}, obs_q[i][63:32], exp_q[i][63:32]);
      check({tag, "_wd"},  obs_q[i][31:0],  exp_q[i][31:0]);
    end
    check({tag, "_count"},    {23'd0, count},    32'(exp_count));
    check({tag, "_err"},      {31'd0, err},      {31'd0, exp_err});
    check({tag, "_done"},     {31'd0, done},     32'd1);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic model_clear();
    exp_count = 0;
    exp_err   = 1'b0;
    exp_done  = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("restart_done",     {31'd0, done},     32'd0);
    check("restart_count",    {23'd0, count},    32'd0);
    check("restart_err",      {31'd0, err},      32'd0);
    model_clear();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_count",    {23'd0, count},    32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("rst_mem_adr",  mem_adr,           BASE);
    check("rst_mem_wd",   mem_wd,            32'd0);
    reset = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int          n;
    bit          last;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    drive_fields(32'd0);
    do_reset();

    // ADD R2,R1,#5 with last: exact write and exact done timing.
    w = {4'hE, 2'b00, 6'b101000, 4'd1, 4'd2, 12'h005};
    put(w, 1'b1);
    check("add_we",  {31'd0, mem_we}, 32'd1);
    check("add_adr", mem_adr, 32'h0000_0000);
    check("add_wd",  mem_wd,  32'hE281_2005);
    @(negedge clk);
    check("add_done",     {31'd0, done},     32'd1);
    check("add_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("add_count",    {23'd0, count},    32'd1);
    finish_session("add");
    restart();

    // LDR, STR, B.
    put({4'hE, 2'b01, 6'b011001, 4'd3, 4'd4, 12'h010}, 1'b0);
    put({4'hE, 2'b01, 6'b011000, 4'd3, 4'd5, 12'h014}, 1'b0);
    put({4'hE, 2'b10, 6'b100000, 4'hF, 4'hF, 12'hFFC}, 1'b1);
    finish_session("three");
    restart();

    // Dropped words: Op=11, then EOR.
    put({4'hE, 2'b11, 6'b000000, 4'd1, 4'd1, 12'h001}, 1'b0);
    put({4'hE, 2'b00, 6'b000100, 4'd1, 4'd2, 12'h003}, 1'b1);
    finish_session("op11");
    restart();
    put({4'hE, 2'b00, 6'b000010, 4'd1, 4'd1, 12'h001}, 1'b0);
    put({4'hE, 2'b00, 6'b000100, 4'd1, 4'd2, 12'h003}, 1'b1);
    finish_session("eor");
    restart();

    // Capacity: six legal words without last.
    for (int i = 0; i < 6; i++) put(make_legal(), 1'b0);
    finish_session("cap");
    restart();

    // start during LOAD is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    put(make_legal(), 1'b0);
    put(make_legal(), 1'b1);
    finish_session("start_in_load");
    restart();

    // Reset during the WRITE cycle of word 2.
    put(make_legal(), 1'b0);
    put(make_legal(), 1'b0);
    check("midrst_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_we_async", {31'd0, mem_we}, 32'd0);
    do_reset();
    put(make_legal(), 1'b1);
    finish_session("after_reset");
    restart();

    // Random sessions with idle gaps, field churn and stray start pulses.
    for (int s = 0; s < 30; s++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(3)) begin
          drive_fields($urandom);
          in_last = 1'($urandom);
          start   = !exp_done && ($urandom_range(3) == 0);
          @(negedge clk);
          start = 1'b0;
        end
        w    = ($urandom_range(2) == 0) ? 32'($urandom) : make_legal();
        last = (i == n - 1) && ($urandom_range(1) == 1);
        put(w, last);
      end
      if (!exp_done) put(32'($urandom), 1'b1);
      finish_session("rand");
      restart();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer-side counterpart to the multicycle control decoder.
- Accepts instruction fields (Cond/Op/Funct/Rn/Rd/Src2) over a valid/ready handshake, packs them into 32-bit ARM words, and rejects encodings the decoder cannot execute.
- Writes legal words sequentially into unified instruction/data memory and holds the CPU in reset until loading completes.
- Sits between the test/boot host and the memory write port, ahead of the multicycle datapath.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- MAX_WORDS, 64, program capacity in words (power of two, 2..256).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  in DONE, begin a new load session.
- in_valid  in  1  host presents a field set.
- in_ready  out  1  block accepts a field set this cycle.
- in_last  in  1  qualifies in_valid: final instruction of the program.
- Cond  in  4  condition field.
- Op  in  2  opcode class.
- Funct  in  6  function field.
- Rn  in  4  first source register.
- Rd  in  4  destination register.
- Src2  in  12  operand 2 / offset.
- mem_we  out  1  memory write strobe.
- mem_adr  out  32  memory byte address.
- mem_wd  out  32  memory write data.
- cpu_hold  out  1  high keeps the CPU in reset.
- done  out  1  load session complete.
- err  out  1  sticky: an illegal word was dropped.
- count  out  9  words written this session.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=LOAD, count=0, err=0.
  - cpu_hold=1, done=0, mem_we=0.
  - mem_adr=BASE_ADDR, mem_wd=0.
- Packing: word = {Cond, Op, Funct, Rn, Rd, Src2}, i.e. [31:28] [27:26] [25:20] [19:16] [15:12] [11:0]. The same layout applies to all classes; for branches Funct[3:0]/Rn/Rd/Src2 together form imm24.
- Legality (evaluated on the accepted fields):
  - Op=11: illegal.
  - Op=10 with Funct[5]=0: illegal.
  - Op=00 with Funct[4:1] not in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR}: illegal.
  - Op=01: always legal.
- FSM states: LOAD, WRITE, DONE.
- LOAD:
  - in_ready=1, mem_we=0.
  - A handshake (in_valid & in_ready) latches the packed word and in_last.
  - Legal word: go to WRITE.
  - Illegal word: set err, do not write, count unchanged. If in_last go to DONE, else stay in LOAD.
- WRITE:
  - in_ready=0.
  - mem_we=1 for exactly one cycle; mem_adr = BASE_ADDR + 4*count; mem_wd = latched word.
  - On exit, count increments.
  - Latched last, or count reaching MAX_WORDS after the increment: go to DONE.
  - Otherwise: return to LOAD.
- DONE:
  - done=1, cpu_hold=0, in_ready=0, mem_we=0.
  - count and err hold their values.
  - start=1: go to LOAD next cycle; clear count and err, set cpu_hold=1, done=0.
- Throughput: at most one word per 2 cycles. The first accept can occur in the first clock after reset deasserts.
- mem_adr/mem_wd are registered and only meaningful while mem_we=1.
- Boundaries:
  - Capacity: reaching count=MAX_WORDS without in_last still goes to DONE. Further in_valid is refused (in_ready=0) and err is not set.
  - start outside DONE is ignored.
  - in_valid=0 in LOAD: the FSM idles indefinitely and holds the CPU.
  - Field inputs are sampled only on the handshake cycle; changing them at any other time has no effect.
  - Reset asserted mid-session (including during WRITE): mem_we drops immediately, the partial program is abandoned, and the block restarts at BASE_ADDR.

Test Plan:
- Reset release, then ADD R2,R1,#5 (Cond=1110, Op=00, Funct=101000, Rn=1, Rd=2, Src2=005) with last -> mem_we pulses once with adr=0, wd=32'hE281_2005. The next cycle shows done=1, cpu_hold=0, count=1.
- Three words (LDR, STR, B with Funct=100000, last on the third) -> writes to adr 0, 4, 8; in_ready is low during each WRITE cycle; done after count=3.
- Op=11 word, then a legal SUB with last -> err=1, only the SUB is written at adr 0, count=1. Repeat with Op=00 Funct[4:1]=0001 (EOR) -> same dropped-word behaviour.
- MAX_WORDS=4 with 6 words and no last -> exactly 4 writes (adr 0..12), then DONE; words 5 and 6 are never accepted (in_ready=0); err=0.
- In DONE, pulse start, then load one word -> cpu_hold reasserts, count and err clear, the word is written at adr 0. A start pulse during LOAD has no effect.
- Assert reset in the WRITE cycle of word 2 -> mem_we deasserts asynchronously; after release, state=LOAD, count=0, and the next write goes to adr 0.
